// File: rtl/ofs_plat_avalon_mem_rdwr_responder_pkg.sv
// Shared types and constants for the split-bus Avalon memory responder.
//   rd_state_e : read-channel FSM states
//   wr_state_e : write-channel FSM states
//   RESP_*     : Avalon response codes driven on rd_response / wr_response
package ofs_plat_avalon_mem_rdwr_responder_pkg;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE  = 2'b00,
    W_BURST = 2'b01,
    W_RESP  = 2'b10
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ofs_plat_avalon_mem_rdwr_responder_ram.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read
// port with one cycle of latency. A same-cycle read and write to the same
// index returns the data held before the write.
//   clk     : rising-edge clock
//   we_i    : write enable
//   waddr_i : write word index
//   wdata_i : write data
//   wbe_i   : write byte enables
//   re_i    : read enable
//   raddr_i : read word index
//   rdata_o : read data, valid the cycle after re_i
module ofs_plat_avalon_mem_rdwr_responder_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wbe_i,
  input  logic                    re_i,
  input  logic [ADDR_WIDTH-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage has no reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (wbe_i[b]) begin
          mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ofs_plat_avalon_mem_rdwr_responder.sv
// Avalon split-bus memory sink. Read and write channels are served by
// independent FSMs sharing one simple dual-port RAM indexed by the low
// RAM_ADDR_WIDTH bits of the word address (bursts wrap inside the RAM).
// A burstcount of zero is handled as a single beat flagged SLVERR.
//   clk, reset_n                 : clock, async active-low reset
//   rd_read/address/burstcount   : read request (rd_byteenable ignored)
//   rd_waitrequest               : high while a read burst is being issued
//   rd_readdatavalid/data/resp   : read beats, one cycle after RAM read
//   wr_write/address/burstcount  : write beats (address/count from beat 0)
//   wr_writedata/byteenable      : write payload
//   wr_waitrequest               : high only while the response is sent
//   wr_writeresponsevalid/resp   : one response per write burst
module ofs_plat_avalon_mem_rdwr_responder
  import ofs_plat_avalon_mem_rdwr_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = 7,
  parameter int unsigned RAM_ADDR_WIDTH  = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,

  input  logic                       rd_read,
  input  logic [ADDR_WIDTH-1:0]      rd_address,
  input  logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
  input  logic [DATA_WIDTH/8-1:0]    rd_byteenable,
  output logic                       rd_waitrequest,
  output logic                       rd_readdatavalid,
  output logic [DATA_WIDTH-1:0]      rd_readdata,
  output logic [1:0]                 rd_response,

  input  logic                       wr_write,
  input  logic [ADDR_WIDTH-1:0]      wr_address,
  input  logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
  input  logic [DATA_WIDTH-1:0]      wr_writedata,
  input  logic [DATA_WIDTH/8-1:0]    wr_byteenable,
  output logic                       wr_waitrequest,
  output logic                       wr_writeresponsevalid,
  output logic [1:0]                 wr_response
);

  localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE = BURST_CNT_WIDTH'(1);
  localparam logic [RAM_ADDR_WIDTH-1:0]  RA_ONE = RAM_ADDR_WIDTH'(1);

  // ---------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------
  rd_state_e                  rd_state_q, rd_state_d;
  logic [RAM_ADDR_WIDTH-1:0]  rd_addr_q,  rd_addr_d;
  logic [BURST_CNT_WIDTH-1:0] rd_beat_q,  rd_beat_d;
  logic [BURST_CNT_WIDTH-1:0] rd_last_q,  rd_last_d;
  logic                       rd_err_q,   rd_err_d;
  logic                       rd_valid_q, rd_valid_d;
  logic [1:0]                 rd_resp_q,  rd_resp_d;
  logic                       rd_wait_q,  rd_wait_d;
  logic                       ram_re_c;

  // Read next-state: one RAM read per R_BURST cycle, valid follows a cycle later.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_beat_d  = rd_beat_q;
    rd_last_d  = rd_last_q;
    rd_err_d   = rd_err_q;
    rd_valid_d = 1'b0;
    rd_resp_d  = RESP_OKAY;
    ram_re_c   = 1'b0;

    case (rd_state_q)
      R_IDLE: begin
        if (rd_read) begin
          rd_addr_d  = rd_address[RAM_ADDR_WIDTH-1:0];
          rd_beat_d  = '0;
          rd_last_d  = (rd_burstcount == '0) ? '0 : rd_burstcount - BC_ONE;
          rd_err_d   = (rd_burstcount == '0);
          rd_state_d = R_BURST;
        end
      end
      R_BURST: begin
        ram_re_c   = 1'b1;
        rd_valid_d = 1'b1;
        rd_resp_d  = rd_err_q ? RESP_SLVERR : RESP_OKAY;
        rd_addr_d  = rd_addr_q + RA_ONE;
        rd_beat_d  = rd_beat_q + BC_ONE;
        if (rd_beat_q == rd_last_q) begin
          rd_beat_d  = '0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase

    rd_wait_d = (rd_state_d == R_BURST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_beat_q  <= '0;
      rd_last_q  <= '0;
      rd_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_resp_q  <= RESP_OKAY;
      rd_wait_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_beat_q  <= rd_beat_d;
      rd_last_q  <= rd_last_d;
      rd_err_q   <= rd_err_d;
      rd_valid_q <= rd_valid_d;
      rd_resp_q  <= rd_resp_d;
      rd_wait_q  <= rd_wait_d;
    end
  end

  // ---------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------
  wr_state_e                  wr_state_q,  wr_state_d;
  logic [RAM_ADDR_WIDTH-1:0]  wr_addr_q,   wr_addr_d;
  logic [BURST_CNT_WIDTH-1:0] wr_beat_q,   wr_beat_d;
  logic [BURST_CNT_WIDTH-1:0] wr_last_q,   wr_last_d;
  logic                       wr_err_q,    wr_err_d;
  logic                       wr_rvalid_q, wr_rvalid_d;
  logic [1:0]                 wr_resp_q,   wr_resp_d;
  logic                       wr_wait_q,   wr_wait_d;
  logic                       ram_we_c;
  logic [RAM_ADDR_WIDTH-1:0]  ram_waddr_c;

  // Write next-state: beat 0 writes straight from the bus address, later
  // beats from the running index; bubbles (wr_write low) leave state alone.
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_addr_d   = wr_addr_q;
    wr_beat_d   = wr_beat_q;
    wr_last_d   = wr_last_q;
    wr_err_d    = wr_err_q;
    ram_we_c    = 1'b0;
    ram_waddr_c = wr_addr_q;

    case (wr_state_q)
      W_IDLE: begin
        if (wr_write) begin
          ram_we_c    = 1'b1;
          ram_waddr_c = wr_address[RAM_ADDR_WIDTH-1:0];
          wr_addr_d   = wr_address[RAM_ADDR_WIDTH-1:0] + RA_ONE;
          wr_beat_d   = BC_ONE;
          wr_last_d   = (wr_burstcount == '0) ? '0 : wr_burstcount - BC_ONE;
          wr_err_d    = (wr_burstcount == '0);
          wr_state_d  = (wr_burstcount <= BC_ONE) ? W_RESP : W_BURST;
        end
      end
      W_BURST: begin
        if (wr_write) begin
          ram_we_c  = 1'b1;
          wr_addr_d = wr_addr_q + RA_ONE;
          wr_beat_d = wr_beat_q + BC_ONE;
          if (wr_beat_q == wr_last_q) begin
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        wr_beat_d  = '0;
        wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase

    // Response outputs are registered copies of "next state is W_RESP".
    wr_rvalid_d = (wr_state_d == W_RESP);
    wr_wait_d   = (wr_state_d == W_RESP);
    wr_resp_d   = ((wr_state_d == W_RESP) && wr_err_d) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q  <= W_IDLE;
      wr_addr_q   <= '0;
      wr_beat_q   <= '0;
      wr_last_q   <= '0;
      wr_err_q    <= 1'b0;
      wr_rvalid_q <= 1'b0;
      wr_resp_q   <= RESP_OKAY;
      wr_wait_q   <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_addr_q   <= wr_addr_d;
      wr_beat_q   <= wr_beat_d;
      wr_last_q   <= wr_last_d;
      wr_err_q    <= wr_err_d;
      wr_rvalid_q <= wr_rvalid_d;
      wr_resp_q   <= wr_resp_d;
      wr_wait_q   <= wr_wait_d;
    end
  end

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  ofs_plat_avalon_mem_rdwr_responder_ram #(
    .ADDR_WIDTH (RAM_ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_c),
    .waddr_i (ram_waddr_c),
    .wdata_i (wr_writedata),
    .wbe_i   (wr_byteenable),
    .re_i    (ram_re_c),
    .raddr_i (rd_addr_q),
    .rdata_o (rd_readdata)
  );

  // Read byteenable and address bits above the RAM index carry no meaning here.
  logic unused_c;
  assign unused_c = ^{rd_byteenable, rd_address, wr_address};

  assign rd_waitrequest        = rd_wait_q;
  assign rd_readdatavalid      = rd_valid_q;
  assign rd_response           = rd_resp_q;
  assign wr_waitrequest        = wr_wait_q;
  assign wr_writeresponsevalid = wr_rvalid_q;
  assign wr_response           = wr_resp_q;

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_responder.sv
// Directed bench for ofs_plat_avalon_mem_rdwr_responder: expected read beats
// and write responses are queued with their due cycle when stimulus is
// driven, and checked every cycle against the DUT outputs.
module tb_ofs_plat_avalon_mem_rdwr_responder;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 512;
  localparam int unsigned BW  = 7;
  localparam int unsigned RAW = 10;
  localparam int unsigned BEW = DW / 8;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           rd_read;
  logic [AW-1:0]  rd_address;
  logic [BW-1:0]  rd_burstcount;
  logic [BEW-1:0] rd_byteenable;
  logic           rd_waitrequest;
  logic           rd_readdatavalid;
  logic [DW-1:0]  rd_readdata;
  logic [1:0]     rd_response;
  logic           wr_write;
  logic [AW-1:0]  wr_address;
  logic [BW-1:0]  wr_burstcount;
  logic [DW-1:0]  wr_writedata;
  logic [BEW-1:0] wr_byteenable;
  logic           wr_waitrequest;
  logic           wr_writeresponsevalid;
  logic [1:0]     wr_response;

  ofs_plat_avalon_mem_rdwr_responder #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .BURST_CNT_WIDTH (BW),
    .RAM_ADDR_WIDTH  (RAW)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .rd_read               (rd_read),
    .rd_address            (rd_address),
    .rd_burstcount         (rd_burstcount),
    .rd_byteenable         (rd_byteenable),
    .rd_waitrequest        (rd_waitrequest),
    .rd_readdatavalid      (rd_readdatavalid),
    .rd_readdata           (rd_readdata),
    .rd_response           (rd_response),
    .wr_write              (wr_write),
    .wr_address            (wr_address),
    .wr_burstcount         (wr_burstcount),
    .wr_writedata          (wr_writedata),
    .wr_byteenable         (wr_byteenable),
    .wr_waitrequest        (wr_waitrequest),
    .wr_writeresponsevalid (wr_writeresponsevalid),
    .wr_response           (wr_response)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    int            cyc;
  } rd_exp_t;

  typedef struct {
    logic [1:0] resp;
    int         cyc;
  } wr_exp_t;

  rd_exp_t       rd_q[$];
  wr_exp_t       wr_q[$];
  logic [DW-1:0] mem_m [1 << RAW];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_mis = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check any beat or response due in that cycle.
  task automatic tick();
    rd_exp_t re;
    wr_exp_t we;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      re = rd_q.pop_front();
      chk("rd_valid", DW'(rd_readdatavalid), DW'(1));
      chk("rd_data", rd_readdata, re.data);
      chk("rd_resp", DW'(rd_response), DW'(re.resp));
    end else begin
      chk("rd_spurious_valid", DW'(rd_readdatavalid), DW'(0));
    end
    if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
      we = wr_q.pop_front();
      chk("wr_resp_valid", DW'(wr_writeresponsevalid), DW'(1));
      chk("wr_resp", DW'(wr_response), DW'(we.resp));
    end else begin
      chk("wr_spurious_resp", DW'(wr_writeresponsevalid), DW'(0));
    end
  endtask

  task automatic wait_wr_ready();
    int n = 0;
    while (wr_waitrequest && n < 20) begin
      tick();
      n++;
    end
    chk("wr_ready_timeout", DW'(wr_waitrequest), DW'(0));
  endtask

  task automatic wait_rd_ready();
    int n = 0;
    while (rd_waitrequest && n < 300) begin
      tick();
      n++;
    end
    chk("rd_ready_timeout", DW'(rd_waitrequest), DW'(0));
  endtask

  task automatic drain();
    int n = 0;
    while ((rd_q.size() > 0 || wr_q.size() > 0) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_rd_left", DW'(rd_q.size()), DW'(0));
    chk("drain_wr_left", DW'(wr_q.size()), DW'(0));
  endtask

  task automatic wr_burst(input logic [AW-1:0] addr, input logic [BW-1:0] cnt,
                          input logic [DW-1:0] base, input logic [BEW-1:0] be,
                          input bit bubble);
    int            nb;
    logic [RAW-1:0] idx;
    logic [DW-1:0]  d;
    wr_exp_t        e;
    nb = (cnt == 0) ? 1 : int'(cnt);
    for (int i = 0; i < nb; i++) begin
      wait_wr_ready();
      d              = base + DW'(i);
      wr_write       = 1'b1;
      wr_address     = addr;
      wr_burstcount  = cnt;
      wr_writedata   = d;
      wr_byteenable  = be;
      idx            = RAW'(addr + AW'(i));
      for (int b = 0; b < int'(BEW); b++) begin
        if (be[b]) mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
      end
      if (i == nb - 1) begin
        e.resp = (cnt == 0) ? SLVERR : OKAY;
        e.cyc  = cyc + 1;
        wr_q.push_back(e);
      end
      tick();
      wr_write = 1'b0;
      if (i == nb - 1) begin
        chk("wr_waitrequest_resp", DW'(wr_waitrequest), DW'(1));
      end else if (bubble && i == 0) begin
        // Garbage on an idle cycle must not be written.
        wr_writedata = '1;
        wr_address   = '1;
        tick();
      end
    end
    tick();
    chk("wr_waitrequest_idle", DW'(wr_waitrequest), DW'(0));
  endtask

  task automatic rd_burst(input logic [AW-1:0] addr, input logic [BW-1:0] cnt);
    int       nb;
    rd_exp_t  e;
    nb = (cnt == 0) ? 1 : int'(cnt);
    wait_rd_ready();
    rd_read       = 1'b1;
    rd_address    = addr;
    rd_burstcount = cnt;
    rd_byteenable = '1;
    for (int i = 0; i < nb; i++) begin
      e.data = mem_m[RAW'(addr + AW'(i))];
      e.resp = (cnt == 0) ? SLVERR : OKAY;
      e.cyc  = cyc + 2 + i;
      rd_q.push_back(e);
    end
    tick();
    rd_read = 1'b0;
    for (int i = 0; i < nb; i++) begin
      chk("rd_waitrequest_busy", DW'(rd_waitrequest), DW'(1));
      tick();
    end
    chk("rd_waitrequest_idle", DW'(rd_waitrequest), DW'(0));
    drain();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_valid"}, DW'(rd_readdatavalid), DW'(0));
    chk({tag, "_rd_wait"},  DW'(rd_waitrequest), DW'(0));
    chk({tag, "_rd_resp"},  DW'(rd_response), DW'(OKAY));
    chk({tag, "_wr_valid"}, DW'(wr_writeresponsevalid), DW'(0));
    chk({tag, "_wr_wait"},  DW'(wr_waitrequest), DW'(0));
    chk({tag, "_wr_resp"},  DW'(wr_response), DW'(OKAY));
  endtask

  initial begin
    rd_exp_t e;
    logic [DW-1:0] ones;
    ones          = '1;
    reset_n       = 1'b0;
    rd_read       = 1'b0;
    rd_address    = '0;
    rd_burstcount = '0;
    rd_byteenable = '0;
    wr_write      = 1'b0;
    wr_address    = '0;
    wr_burstcount = '0;
    wr_writedata  = '0;
    wr_byteenable = '0;
    for (int i = 0; i < (1 << RAW); i++) mem_m[i] = '0;

    repeat (3) tick();
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    tick();
    chk_idle_outputs("post_reset");

    // Basic 4-beat write then read at 0x10.
    wr_burst(32'h10, 7'd4, DW'('hA0), '1, 1'b0);
    rd_burst(32'h10, 7'd4);

    // Wrap across the top of the RAM, with a bubble inside the write burst.
    wr_burst(32'h3FE, 7'd4, DW'('hB0), '1, 1'b1);
    rd_burst(32'h3FE, 7'd4);
    // Upper address bits are ignored: 0x400 aliases index 0.
    rd_burst(32'h400, 7'd2);

    // Byte-enable write over a zeroed word.
    wr_burst(32'h20, 7'd1, '0, '1, 1'b0);
    wr_burst(32'h20, 7'd1, ones, BEW'(1), 1'b0);
    rd_burst(32'h20, 7'd1);
    chk("byteenable_model", mem_m[10'h20], DW'('hFF));

    // Zero burstcount: single beat, SLVERR on both channels.
    wr_burst(32'h40, 7'd0, DW'('hC5), '1, 1'b0);
    rd_burst(32'h40, 7'd0);

    // Maximum burst length.
    wr_burst(32'h100, 7'd127, DW'('h5000), '1, 1'b0);
    rd_burst(32'h100, 7'd127);

    // Reset in the middle of a read after beat 1.
    wait_rd_ready();
    rd_read       = 1'b1;
    rd_address    = 32'h10;
    rd_burstcount = 7'd4;
    for (int i = 0; i < 2; i++) begin
      e.data = mem_m[RAW'(32'h10 + i)];
      e.resp = OKAY;
      e.cyc  = cyc + 2 + i;
      rd_q.push_back(e);
    end
    tick();
    rd_read = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    chk_idle_outputs("after_abort");
    rd_burst(32'h10, 7'd4);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ofs_plat_avalon_mem_rdwr_responder.md
OFS_PLAT_AVALON_MEM_RDWR_RESPONDER -- requirements
Module: ofs_plat_avalon_mem_rdwr_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-independent word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, data width in bits.
REQ-003 SHALL have parameter BURST_CNT_WIDTH, default 7, burstcount width.
REQ-004 SHALL have parameter RAM_ADDR_WIDTH, default 10, log2 of internal RAM depth in words.
REQ-005 SHALL use one clock; reset is asynchronous and active-low: clk input 1 (rising-edge clock); reset_n input 1 (async active-low reset).
REQ-006 SHALL have read-request ports: rd_read in 1 (request); rd_address in ADDR_WIDTH (start word); rd_burstcount in BURST_CNT_WIDTH (beats); rd_byteenable in DATA_WIDTH/8 (ignored); rd_waitrequest out 1 (stall).
REQ-007 SHALL have read-response ports: rd_readdatavalid out 1 (beat valid); rd_readdata out DATA_WIDTH (beat data); rd_response out 2 (00 OKAY, 10 SLVERR).
REQ-008 SHALL have write-request ports: wr_write in 1; wr_address in ADDR_WIDTH; wr_burstcount in BURST_CNT_WIDTH; wr_writedata in DATA_WIDTH; wr_byteenable in DATA_WIDTH/8; wr_waitrequest out 1.
REQ-009 SHALL have write-response ports: wr_writeresponsevalid out 1 (one per burst); wr_response out 2.

Function
REQ-010 SHALL act as split-bus sink terminating both channels on an internal simple dual-port RAM (one write port, one registered read port, read latency 1).
REQ-011 SHALL index RAM with the low RAM_ADDR_WIDTH bits of the address; upper bits ignored; beat i of a burst uses (start+i) mod 2^RAM_ADDR_WIDTH.
REQ-012 Read FSM SHALL have states R_IDLE, R_BURST; rd_waitrequest=0 only in R_IDLE.
REQ-013 Request accepted in cycle N (rd_read & !rd_waitrequest) SHALL latch address/burstcount, enter R_BURST in N+1, issue one RAM read per cycle from N+1.
REQ-014 Beat i SHALL appear with rd_readdatavalid=1 in cycle N+2+i; beats contiguous, in address order.
REQ-015 Read FSM SHALL return to R_IDLE in the cycle after the last beat is issued; next request acceptable then.
REQ-016 rd_burstcount==0 SHALL be treated as one beat with rd_response=10 on that beat; all other beats carry 00.
REQ-017 Write FSM SHALL have states W_IDLE, W_BURST, W_RESP; wr_waitrequest=1 only in W_RESP.
REQ-018 First accepted beat SHALL latch address/burstcount and write beat 0; each subsequent accepted beat writes start+i; wr_byteenable masks bytes; wr_address/wr_burstcount ignored on non-first beats.
REQ-019 Cycles with wr_write=0 inside a burst SHALL be idle bubbles, no counter advance.
REQ-020 After the last beat accepted in cycle M, SHALL enter W_RESP, pulse wr_writeresponsevalid for exactly cycle M+1, return to W_IDLE in M+2.
REQ-021 wr_burstcount==0 SHALL be a one-beat burst with wr_response=10; otherwise 00.
REQ-022 Same-cycle RAM read and write to one index SHALL return old data.
REQ-023 Beat counters SHALL be BURST_CNT_WIDTH bits; max burstcount 2^BURST_CNT_WIDTH-1 handled without overflow.

Reset
REQ-024 On reset_n=0: both FSMs idle, counters 0, rd_readdatavalid=0, wr_writeresponsevalid=0, rd_response=wr_response=00, rd_waitrequest=wr_waitrequest=0 from release; rd_readdata undefined.
REQ-025 Reset mid-burst SHALL abort outstanding beats and responses; RAM contents retained, no response for aborted bursts.

Structure
REQ-026 Package ofs_plat_avalon_mem_rdwr_responder_pkg SHALL hold read/write state enums and response-code constants (RESP_OKAY=00, RESP_SLVERR=10).
REQ-027 RAM SHALL be sub-module ofs_plat_avalon_mem_rdwr_responder_ram (simple dual-port, registered read, byte-enable write).

Verification
REQ-028 Write burst addr 0x10, count 4, data 0xA0..0xA3, full byteenable -> one wr_writeresponsevalid one cycle after beat 3, response 00.
REQ-029 Read addr 0x10 count 4 accepted cycle N -> readdatavalid N+2..N+5, data 0xA0..0xA3, rd_waitrequest high N+1..N+4.
REQ-030 Write addr 0x3FE count 4 (RAM_ADDR_WIDTH=10), then read 0x3FE count 4 -> data in order, indices 0x3FE,0x3FF,0x000,0x001.
REQ-031 Write byteenable 0x...01 data all-ones over zeroed word -> readback only byte 0 = 0xFF.
REQ-032 reset_n low during a 4-beat read after beat 1 -> no further readdatavalid; new request accepted after release returns correct data.
REQ-033 rd_burstcount=0 and wr_burstcount=0 -> single beat/response each with response 10.
